// File: rtl/instr_mem_arb.sv
// rtl/instr_mem_arb.sv - instruction memory: ROM/RAM fetch port plus loader write port
// with single-port RAM conflict arbitration, starvation guard and write lock.
module instr_mem_arb #(
    parameter int ADDR_W     = 14,
    parameter int RAM_WORDS  = 2048,
    parameter int ROM_WORDS  = 128,
    parameter int READ_LAT   = 1,
    parameter int LOAD_PRIO  = 0,
    parameter int STARVE_MAX = 3,
    localparam int ROM_AW    = $clog2(ROM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-2:0] ld_addr_i,
    input  logic [31:0]       ld_wdata_i,
    input  logic [3:0]        ld_be_i,
    output logic              ld_gnt_o,
    output logic              ld_err_o,
    input  logic              lock_i
);

    localparam int IDX_W  = ADDR_W - 3;
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W:0] RAM_LIM = (IDX_W + 1)'(RAM_WORDS);
    localparam logic [IDX_W:0] ROM_LIM = (IDX_W + 1)'(ROM_WORDS);
    localparam logic [CNT_W-1:0] STARVE = CNT_W'(STARVE_MAX);

    logic [IDX_W-1:0]  f_idx, ld_idx;
    logic [RAM_AW-1:0] f_widx, ld_widx;
    logic              f_is_ram, f_ram_ok, f_rom_ok, ld_ok;
    logic              conflict, fetch_wins, wr_en, rd_en;
    logic [CNT_W-1:0]  f_loss, l_loss;
    logic              lock_q;
    logic [31:0]       mem [RAM_WORDS];
    logic [31:0]       ram_q, rom_q, data1;
    logic              v1, e1, sel_ram;
    logic              unused_bits;

    assign unused_bits = ^{addr_i[1:0], ld_addr_i[1:0]};

    assign f_idx      = addr_i[ADDR_W-2:2];
    assign ld_idx     = ld_addr_i[ADDR_W-2:2];
    assign f_widx     = f_idx[RAM_AW-1:0];
    assign ld_widx    = ld_idx[RAM_AW-1:0];
    assign rom_addr_o = addr_i[2 +: ROM_AW];

    assign f_is_ram = addr_i[ADDR_W-1];
    assign f_ram_ok = f_is_ram && ({1'b0, f_idx} < RAM_LIM);
    assign f_rom_ok = !f_is_ram && ({1'b0, f_idx} < ROM_LIM);
    assign ld_ok    = {1'b0, ld_idx} < RAM_LIM;

    // Only requests that actually need the RAM port can collide.
    assign conflict = req_i && f_ram_ok && ld_req_i && ld_ok;

    always_comb begin
        fetch_wins = (LOAD_PRIO == 0);
        if (f_loss == STARVE) begin
            fetch_wins = 1'b1;
        end else if (l_loss == STARVE) begin
            fetch_wins = 1'b0;
        end
    end

    assign gnt_o    = req_i && !(conflict && !fetch_wins);
    assign ld_gnt_o = ld_req_i && !(conflict && fetch_wins);
    assign wr_en    = ld_gnt_o && ld_ok && !lock_q;
    assign rd_en    = gnt_o && f_ram_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_loss   <= '0;
            l_loss   <= '0;
            lock_q   <= 1'b0;
            ld_err_o <= 1'b0;
        end else begin
            f_loss   <= (!req_i || gnt_o) ? '0 : f_loss + 1'b1;
            l_loss   <= (!ld_req_i || ld_gnt_o) ? '0 : l_loss + 1'b1;
            lock_q   <= lock_q || lock_i;
            ld_err_o <= ld_gnt_o && (|ld_be_i) && (lock_q || !ld_ok);
        end
    end

    // Write lands at the end of the grant cycle, so a fetch one cycle later sees it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be_i[b]) begin
                    mem[ld_widx][8*b +: 8] <= ld_wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[f_widx];
        end
    end

    // Stage registers only move on a grant so response data holds between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1      <= 1'b0;
            e1      <= 1'b0;
            sel_ram <= 1'b0;
            rom_q   <= '0;
        end else begin
            v1 <= gnt_o;
            if (gnt_o) begin
                sel_ram <= f_ram_ok;
                e1      <= !(f_ram_ok || f_rom_ok);
                rom_q   <= f_rom_ok ? rom_data_i : 32'h0;
            end
        end
    end

    assign data1 = sel_ram ? ram_q : rom_q;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        v2, e2;
            logic [31:0] d2;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        e2 <= e1;
                        d2 <= data1;
                    end
                end
            end
            assign rvalid_o = v2;
            assign rdata_o  = d2;
            assign err_o    = e2;
        end else begin : g_lat1
            assign rvalid_o = v1;
            assign rdata_o  = data1;
            assign err_o    = e1;
        end
    endgenerate

endmodule

// File: doc/instr_mem_arb.md
# instr_mem_arb

Parametrised instruction memory for the bus fabric. It serves core instruction fetches over a req/gnt/rvalid handshake from two regions: an external combinational boot ROM and an internal single-port RAM. The RAM is shared with a loader write port, which the flash/boot loader uses to fill it at run time. The block adds conflict arbitration with anti-starvation, byte-enable writes, a sticky write lock, out-of-range error reporting and a 1- or 2-cycle read pipeline.

## Interface
- ADDR_W, 14, fetch byte-address width; bit ADDR_W-1 selects the region: 0 = ROM, 1 = RAM.
- RAM_WORDS, 2048, RAM depth in 32-bit words; must be ≤ 2^(ADDR_W-3).
- ROM_WORDS, 128, ROM depth in words.
- READ_LAT, 1, cycles from accepted fetch to rvalid_o; legal values are 1 and 2.
- LOAD_PRIO, 0, winner of a RAM conflict when neither side is starving: 0 = fetch, 1 = loader.
- STARVE_MAX, 3, number of consecutive conflict losses after which the loser wins the next conflict.

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  fetch request
- addr_i  in  ADDR_W  fetch byte address; bits [1:0] are ignored
- gnt_o  out  1  fetch accepted this cycle (combinational)
- rvalid_o  out  1  fetch response valid
- rdata_o  out  32  fetch response data
- err_o  out  1  response error; qualified by rvalid_o
- rom_addr_o  out  $clog2(ROM_WORDS)  word address to the external ROM, driven from addr_i
- rom_data_i  in  32  ROM data, combinational from rom_addr_o
- ld_req_i  in  1  loader write request
- ld_addr_i  in  ADDR_W-1  loader byte address into RAM; bits [1:0] are ignored
- ld_wdata_i  in  32  loader write data
- ld_be_i  in  4  loader byte enables; bit n covers data[8n+7:8n]
- ld_gnt_o  out  1  loader request accepted this cycle (combinational)
- ld_err_o  out  1  one-cycle pulse, the cycle after an accepted write that was dropped
- lock_i  in  1  sets the sticky write lock when sampled high

## Operation
- **ROM fetch** (addr_i[ADDR_W-1]=0):
  - Always granted.
  - rom_data_i is captured in the grant cycle.
  - A word index ≥ ROM_WORDS returns data 0 with err_o=1.
- **RAM fetch** (addr_i[ADDR_W-1]=1):
  - Word index is addr_i[ADDR_W-2:2].
  - Index ≥ RAM_WORDS: granted; returns data 0 with err_o=1; takes no RAM cycle and never conflicts.
- **Loader write:**
  - Writes the bytes selected by ld_be_i to RAM word ld_addr_i[ADDR_W-2:2].
  - ld_be_i=0 is a granted no-op with no error.
  - An accepted write is dropped, and ld_err_o pulses, when the lock is set or the index ≥ RAM_WORDS.
- **Conflict:** req_i on an in-range RAM address and ld_req_i in the same cycle. The RAM is single-port, so exactly one side is granted.
  - Default winner is set by LOAD_PRIO.
  - Each side has a loss counter. It increments on every lost conflict and clears when that side is granted or drops its request.
  - A side whose counter equals STARVE_MAX wins the next conflict, overriding LOAD_PRIO.
- **Without a conflict**, any request is granted in its own cycle.
- **Ordering:** a write accepted in cycle N is visible to a fetch accepted in cycle N+1 or later.
- **Lock:** set on the first clk_i edge with lock_i=1; cleared only by reset. A write accepted in the same cycle that lock_i is first sampled high still commits.
- **Response data:** rdata_o and err_o hold their last values while rvalid_o=0.
- **Reset:**
  - Clears the read pipeline, both loss counters, the lock, ld_err_o, rvalid_o, rdata_o and err_o (all to 0).
  - RAM contents are not reset.
  - An accepted fetch still in flight when reset asserts produces no response.

## Timing
- gnt_o and ld_gnt_o are combinational from the requests, the addresses and the registered loss counters.
- A fetch accepted at edge N gives rvalid_o=1 after edge N+READ_LAT, for exactly one cycle per accepted fetch.
- Throughput is one fetch per cycle. Responses return in acceptance order; there is no backpressure on responses.
- READ_LAT=2 adds one register stage after the RAM/ROM read. rvalid_o, rdata_o and err_o all move together.
- RAM write commits at the edge ending the grant cycle.
- ld_err_o is asserted in cycle N+1 for a write dropped at edge N.

## Test plan
- **Reset values:** assert rst_ni=0 mid-stream with a fetch in flight -> all outputs 0; no rvalid_o after release; lock cleared.
- **ROM vs RAM fetch:**
  - ROM fetch at addr 0x0004 with rom_data_i=0xDEADBEEF, READ_LAT=1 -> rvalid_o one cycle later with rdata_o=0xDEADBEEF, err_o=0.
  - RAM fetch at 0x2000 after loader write 0x12345678 with be=4'b1111 -> 0x12345678.
- **Byte enables:** write 0xAABBCCDD with be=4'b0101 over 0x00000000 -> read 0x00BB00DD. Back-to-back fetches at READ_LAT=2 -> one rvalid_o per cycle, in order.
- **Conflict and starvation:** LOAD_PRIO=0, STARVE_MAX=3, req_i and ld_req_i held on RAM addresses -> fetch granted 3 cycles, loader granted on the 4th, pattern repeats.
- **Lock:** pulse lock_i, then write 0x55 to word 5 -> ld_gnt_o=1, ld_err_o pulses next cycle, word 5 unchanged. Reset -> writes succeed again.
- **Out of range:** RAM_WORDS=1024:
  - Fetch at word 1500 -> rvalid_o with rdata_o=0, err_o=1.
  - Loader write to word 1500 -> ld_err_o pulse, no conflict stall on a concurrent fetch.
